aes_stream_adapter: RTL and testbench
=====================================

AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

Interface
REQ-001 SHALL have parameter WORD_W, default 32: stream word width.
REQ-002 SHALL have parameter BLOCK_W, default 128: AES block width; BLOCK_W/WORD_W words per block (4 by default).
REQ-003 SHALL have ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear.
- ctrl_engine_i  in  ctrl_engine_t  clear/start/enable from the controller FSM.
- flags_engine_o  out  flags_engine_t  busy, done, blk_cnt[15:0].
- nblocks_i  in  16  blocks per job, sampled at start.
- pt_valid_i / pt_ready_o / pt_data_i  in/out/in  1/1/WORD_W  plaintext stream from the source streamer.
- ct_valid_o / ct_ready_i / ct_data_o  out/in/out  1/1/WORD_W  ciphertext stream to the sink streamer.
- core_in_valid_o / core_in_ready_i / core_in_data_o  out/in/out  1/1/BLOCK_W  block to the AES core.
- core_out_valid_i / core_out_ready_o / core_out_data_i  in/out/in  1/1/BLOCK_W  result block from the AES core.

Function
REQ-004 Every handshake SHALL complete on a rising edge with valid&ready both high; a valid held high SHALL keep its data stable until accepted.
REQ-005 The FSM SHALL have states IDLE, LOAD, ISSUE, WAIT_CORE, DRAIN, DONE.
REQ-006 IDLE->LOAD on ctrl_engine_i.start with nblocks_i!=0, latching nblocks_i; IDLE->DONE on start with nblocks_i==0.
REQ-007 In LOAD, pt_ready_o=1; each accepted word SHALL shift in, first word into bits [BLOCK_W-1:BLOCK_W-WORD_W] (big-endian); after the 4th word LOAD->ISSUE.
REQ-008 In ISSUE, core_in_valid_o=1, asserted the cycle after the 4th word is accepted; on handshake ISSUE->WAIT_CORE.
REQ-009 In WAIT_CORE, core_out_ready_o=1; on handshake the block SHALL be captured and the FSM SHALL go WAIT_CORE->DRAIN.
REQ-010 In DRAIN, ct_valid_o=1 from the cycle after core capture; words SHALL be emitted MSW first, same order as REQ-007.
- After the 4th accepted word: blk_cnt increments; DRAIN->LOAD if blk_cnt != latched nblocks, else DRAIN->DONE.
REQ-011 DONE SHALL last exactly one cycle with flags_engine_o.done=1, then go to IDLE.
REQ-012 flags_engine_o.busy SHALL be 1 in every state except IDLE.
REQ-013 blk_cnt SHALL reset to 0 on start.
REQ-014 pt_ready_o, core_out_ready_o, core_in_valid_o and ct_valid_o SHALL be 0 outside their respective states.
REQ-015 start SHALL be ignored when not in IDLE.
REQ-016 ctrl_engine_i.enable SHALL have no effect.
REQ-017 clear or ctrl_engine_i.clear SHALL force IDLE on the next edge, zero counters and word indices, and deassert all valid/ready outputs; clear SHALL win over a simultaneous start.
REQ-018 A clear mid-job SHALL discard partial blocks; done SHALL NOT pulse.

Reset
REQ-019 On reset_n low: state=IDLE; all valid/ready outputs, busy, done, blk_cnt, word indices and data registers = 0, regardless of clk.

Structure
REQ-020 ctrl_engine_t, flags_engine_t and the adapter state enum SHALL live in aes_package.
REQ-021 Packing and unpacking SHALL use one sub-module, aes_word_serdes (WORD_W x 4 shift register with load/shift/count), instantiated twice.

Verification
REQ-022 Single block: nblocks=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF -> core_in_data_o=0x00112233445566778899AABBCCDDEEFF; core returns 0x69C4E0D86A7B0430D8CDB78070B4C55A -> ct words 0x69C4E0D8, 0x6A7B0430, 0xD8CDB780, 0x70B4C55A; done pulses once; blk_cnt=1.
REQ-023 nblocks=3 with random pt_valid/ct_ready gaps -> 12 ct words in order, blk_cnt=3, exactly one done pulse.
REQ-024 ct_ready_i held low 5 cycles in DRAIN -> ct_valid_o and ct_data_o stable throughout; core_in_ready_i low 3 cycles -> core_in_data_o stable.
REQ-025 start with nblocks=0 -> no stream or core handshakes, done on cycle 2, busy high exactly one cycle.
REQ-026 clear asserted after 2 plaintext words, then start with nblocks=1 -> first new word lands in MSW; no done from the aborted job; start in the same cycle as clear ignored.
REQ-027 reset_n pulsed low mid-DRAIN asynchronously -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/aes_package.sv
// Shared types for the AES stream adapter.
//   ctrl_engine_t  : clear/start/enable strobes from the controller FSM
//   flags_engine_t : busy, done and completed-block count back to the controller
//   adapter_state_e: adapter FSM states
package aes_package;

    localparam int unsigned BLK_CNT_W = 16;

    typedef struct packed {
        logic clear;
        logic start;
        logic enable;
    } ctrl_engine_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic [BLK_CNT_W-1:0] blk_cnt;
    } flags_engine_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_CORE,
        ST_DRAIN,
        ST_DONE
    } adapter_state_e;

    // Counter width that stays legal for a one-entry counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_word_serdes.sv
// Word <-> block shift register, used both to pack the plaintext stream and
// to unpack the ciphertext block.
//   clk, reset_n     : clock, asynchronous active-low reset
//   clr_i            : synchronous clear of data and word index (highest priority)
//   load_i           : parallel load of load_data_i, word index back to 0
//   shift_i          : shift one word towards the MSW, shift_data_i enters at the LSW
//   data_o           : whole block; the MSW is the oldest word shifted in / next word out
//   last_o           : the word index points at the final word of the block
module aes_word_serdes
    import aes_package::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr_i,
    input  logic                     load_i,
    input  logic [WORD_W*NWORDS-1:0] load_data_i,
    input  logic                     shift_i,
    input  logic [WORD_W-1:0]        shift_data_i,
    output logic [WORD_W*NWORDS-1:0] data_o,
    output logic                     last_o
);

    localparam int unsigned BW    = WORD_W * NWORDS;
    localparam int unsigned CNT_W = cnt_width(NWORDS);

    logic [BW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == CNT_W'(NWORDS - 1));
    assign data_o = data_q;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            data_d = load_data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            data_d = (data_q << WORD_W) | BW'(shift_data_i);
            // Index wraps so the next block starts at word 0 without a reload.
            cnt_d  = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_stream_adapter.sv
// Bridges 32-bit plaintext/ciphertext word streams to a block-wide AES core.
// Per block: collect BLOCK_W/WORD_W words (LOAD), hand the block to the core
// (ISSUE), take the result (WAIT_CORE), stream it out MSW first (DRAIN).
//   clk, reset_n      : clock, asynchronous active-low reset
//   clear             : synchronous abort back to IDLE
//   ctrl_engine_i     : clear/start (enable is ignored)
//   flags_engine_o    : busy, one-cycle done, completed block count
//   nblocks_i         : blocks per job, sampled on start
//   pt_*              : plaintext word stream in
//   ct_*              : ciphertext word stream out
//   core_in_*         : block to the AES core
//   core_out_*        : result block from the AES core
module aes_stream_adapter
    import aes_package::*;
#(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  ctrl_engine_t         ctrl_engine_i,
    output flags_engine_t        flags_engine_o,
    input  logic [BLK_CNT_W-1:0] nblocks_i,
    input  logic                 pt_valid_i,
    output logic                 pt_ready_o,
    input  logic [WORD_W-1:0]    pt_data_i,
    output logic                 ct_valid_o,
    input  logic                 ct_ready_i,
    output logic [WORD_W-1:0]    ct_data_o,
    output logic                 core_in_valid_o,
    input  logic                 core_in_ready_i,
    output logic [BLOCK_W-1:0]   core_in_data_o,
    input  logic                 core_out_valid_i,
    output logic                 core_out_ready_o,
    input  logic [BLOCK_W-1:0]   core_out_data_i
);

    localparam int unsigned NWORDS = BLOCK_W / WORD_W;

    adapter_state_e       state_q, state_d;
    logic [BLK_CNT_W-1:0] nblocks_q, nblocks_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_CNT_W-1:0] blk_cnt_inc;

    logic clr;
    logic pt_fire, core_in_fire, core_out_fire, ct_fire;
    logic pack_last, unpack_last;
    logic [BLOCK_W-1:0] unpack_data;

    assign clr           = clear | ctrl_engine_i.clear;
    assign pt_fire       = pt_valid_i & pt_ready_o;
    assign core_in_fire  = core_in_valid_o & core_in_ready_i;
    assign core_out_fire = core_out_valid_i & core_out_ready_o;
    assign ct_fire       = ct_valid_o & ct_ready_i;
    assign blk_cnt_inc   = blk_cnt_q + BLK_CNT_W'(1);

    // Plaintext packer: words enter at the LSW, so the first word ends in the MSW.
    aes_word_serdes #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS)
    ) u_pack (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (clr),
        .load_i       (1'b0),
        .load_data_i  ('0),
        .shift_i      (pt_fire),
        .shift_data_i (pt_data_i),
        .data_o       (core_in_data_o),
        .last_o       (pack_last)
    );

    // Ciphertext unpacker: loaded from the core, MSW presented first.
    aes_word_serdes #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS)
    ) u_unpack (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (clr),
        .load_i       (core_out_fire),
        .load_data_i  (core_out_data_i),
        .shift_i      (ct_fire),
        .shift_data_i ('0),
        .data_o       (unpack_data),
        .last_o       (unpack_last)
    );

    assign ct_data_o = unpack_data[BLOCK_W-1 -: WORD_W];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            nblocks_q <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            nblocks_q <= nblocks_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        nblocks_d = nblocks_q;
        blk_cnt_d = blk_cnt_q;
        if (clr) begin
            state_d   = ST_IDLE;
            nblocks_d = '0;
            blk_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ctrl_engine_i.start) begin
                        nblocks_d = nblocks_i;
                        blk_cnt_d = '0;
                        state_d   = (nblocks_i != '0) ? ST_LOAD : ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (pt_fire && pack_last) state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (core_in_fire) state_d = ST_WAIT_CORE;
                end
                ST_WAIT_CORE: begin
                    if (core_out_fire) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (ct_fire && unpack_last) begin
                        blk_cnt_d = blk_cnt_inc;
                        state_d   = (blk_cnt_inc != nblocks_q) ? ST_LOAD : ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode (pure function of the state register)
    always_comb begin
        pt_ready_o             = 1'b0;
        core_in_valid_o        = 1'b0;
        core_out_ready_o       = 1'b0;
        ct_valid_o             = 1'b0;
        flags_engine_o.busy    = (state_q != ST_IDLE);
        flags_engine_o.done    = (state_q == ST_DONE);
        flags_engine_o.blk_cnt = blk_cnt_q;
        unique case (state_q)
            ST_LOAD:      pt_ready_o       = 1'b1;
            ST_ISSUE:     core_in_valid_o  = 1'b1;
            ST_WAIT_CORE: core_out_ready_o = 1'b1;
            ST_DRAIN:     ct_valid_o       = 1'b1;
            default:      ;
        endcase
    end

endmodule

// File: tb/tb_aes_stream_adapter.sv
module tb_aes_stream_adapter;
    import aes_package::*;

    localparam logic [127:0] KAT_PT = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] KAT_CT = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    ctrl_engine_t  ctrl_engine_i = '0;
    flags_engine_t flags_engine_o;
    logic [15:0]   nblocks_i = '0;
    logic          pt_valid_i = 1'b0;
    logic          pt_ready_o;
    logic [31:0]   pt_data_i = '0;
    logic          ct_valid_o;
    logic          ct_ready_i = 1'b0;
    logic [31:0]   ct_data_o;
    logic          core_in_valid_o;
    logic          core_in_ready_i = 1'b0;
    logic [127:0]  core_in_data_o;
    logic          core_out_valid_i = 1'b0;
    logic          core_out_ready_o;
    logic [127:0]  core_out_data_i = '0;

    aes_stream_adapter #(.WORD_W(32), .BLOCK_W(128)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clear            (clear),
        .ctrl_engine_i    (ctrl_engine_i),
        .flags_engine_o   (flags_engine_o),
        .nblocks_i        (nblocks_i),
        .pt_valid_i       (pt_valid_i),
        .pt_ready_o       (pt_ready_o),
        .pt_data_i        (pt_data_i),
        .ct_valid_o       (ct_valid_o),
        .ct_ready_i       (ct_ready_i),
        .ct_data_o        (ct_data_o),
        .core_in_valid_o  (core_in_valid_o),
        .core_in_ready_i  (core_in_ready_i),
        .core_in_data_o   (core_in_data_o),
        .core_out_valid_i (core_out_valid_i),
        .core_out_ready_o (core_out_ready_o),
        .core_out_data_i  (core_out_data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in AES core: the known-answer block maps to its ciphertext,
    // anything else gets a cheap reversible scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] b);
        if (b == KAT_PT) return KAT_CT;
        return {b[95:0], b[127:96]} ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    endfunction

    // ---------------- behavioural model + compare process ----------------
    logic [31:0]  pt_q[$];
    logic [127:0] exp_blk_q[$];
    logic [31:0]  exp_ct_q[$];
    logic [31:0]  ct_log[$];
    logic [127:0] last_core_in = '0;
    logic [127:0] ci_data_prev = '0;
    logic [31:0]  ct_data_prev = '0;
    logic [15:0]  model_blk = '0;
    logic [15:0]  job_n = '0;
    logic [127:0] mblk, mres;
    bit   model_busy = 0, model_done = 0, nd, clr_s;
    bit   pend_issue = 0, pend_drain = 0, ci_hold = 0, ct_hold = 0;
    int   ct_words = 0, n_hs = 0, done_cnt = 0, busy_cycles = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            pt_q.delete(); exp_blk_q.delete(); exp_ct_q.delete();
            model_busy = 0; model_done = 0; model_blk = '0; ct_words = 0;
            pend_issue = 0; pend_drain = 0; ci_hold = 0; ct_hold = 0;
        end else begin
            clr_s = clear || ctrl_engine_i.clear;
            check("busy", 128'(flags_engine_o.busy), 128'(model_busy));
            check("done", 128'(flags_engine_o.done), 128'(model_done));
            check("blk_cnt", 128'(flags_engine_o.blk_cnt), 128'(model_blk));
            check("one_phase", 128'($countones({pt_ready_o, core_in_valid_o, core_out_ready_o,
                                                ct_valid_o, flags_engine_o.done}) <= 1), 128'(1));
            if (pend_issue) check("issue_latency", 128'(core_in_valid_o), 128'(1));
            if (pend_drain) check("drain_latency", 128'(ct_valid_o), 128'(1));
            if (ci_hold) begin
                check("core_in_valid_hold", 128'(core_in_valid_o), 128'(1));
                check("core_in_data_hold", core_in_data_o, ci_data_prev);
            end
            if (ct_hold) begin
                check("ct_valid_hold", 128'(ct_valid_o), 128'(1));
                check("ct_data_hold", 128'(ct_data_o), 128'(ct_data_prev));
            end
            if (flags_engine_o.done) done_cnt++;
            if (flags_engine_o.busy) busy_cycles++;
            pend_issue = 0; pend_drain = 0;
            ci_hold = core_in_valid_o && !core_in_ready_i && !clr_s;
            ct_hold = ct_valid_o && !ct_ready_i && !clr_s;
            ci_data_prev = core_in_data_o;
            ct_data_prev = ct_data_o;
            if (clr_s) begin
                pt_q.delete(); exp_blk_q.delete(); exp_ct_q.delete();
                model_busy = 0; model_done = 0; model_blk = '0; ct_words = 0;
            end else begin
                nd = 0;
                if (pt_valid_i && pt_ready_o) begin
                    n_hs++;
                    pt_q.push_back(pt_data_i);
                    if (pt_q.size() == 4) begin
                        exp_blk_q.push_back({pt_q[0], pt_q[1], pt_q[2], pt_q[3]});
                        pt_q.delete();
                        pend_issue = 1;
                    end
                end
                if (core_in_valid_o && core_in_ready_i) begin
                    n_hs++;
                    last_core_in = core_in_data_o;
                    if (exp_blk_q.size() == 0) begin
                        check("core_in_unexpected", core_in_data_o, 128'(0));
                    end else begin
                        mblk = exp_blk_q.pop_front();
                        check("core_in_data", core_in_data_o, mblk);
                        mres = core_fn(mblk);
                        for (int w = 0; w < 4; w++) exp_ct_q.push_back(mres[127-32*w -: 32]);
                    end
                end
                if (core_out_valid_i && core_out_ready_o) begin
                    n_hs++;
                    pend_drain = 1;
                end
                if (ct_valid_o && ct_ready_i) begin
                    n_hs++;
                    ct_log.push_back(ct_data_o);
                    if (exp_ct_q.size() == 0) check("ct_unexpected", 128'(ct_data_o), 128'(0));
                    else check("ct_data", 128'(ct_data_o), 128'(exp_ct_q.pop_front()));
                    ct_words++;
                    if (ct_words % 4 == 0) begin
                        model_blk = model_blk + 16'd1;
                        if (model_blk == job_n) nd = 1;
                    end
                end
                if (ctrl_engine_i.start && !model_busy) begin
                    model_busy = 1; model_blk = '0; job_n = nblocks_i; ct_words = 0;
                    if (nblocks_i == 16'd0) nd = 1;
                end
                if (model_done) model_busy = 0;
                model_done = nd;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] pt_mem [0:15];
    int  core_stall = 0;
    int  core_lat = 2;
    int  sink_hold = 0;
    bit  sink_rand = 0;

    // Ciphertext sink: hold-off counter first, then random or always-ready.
    always @(posedge clk) begin
        #1;
        if (sink_hold > 0 && ct_valid_o) begin
            ct_ready_i = 1'b0;
            sink_hold--;
        end else if (sink_rand) begin
            ct_ready_i = ($urandom_range(0, 2) != 0);
        end else begin
            ct_ready_i = 1'b1;
        end
    end

    // AES core model
    initial begin : core_bfm
        logic [127:0] blk;
        bit hs;
        forever begin
            @(posedge clk); #1;
            if (reset_n && core_in_valid_o) begin
                repeat (core_stall) begin @(posedge clk); #1; end
                core_in_ready_i = 1'b1;
                blk = core_in_data_o;
                @(posedge clk); #1;
                core_in_ready_i = 1'b0;
                repeat (core_lat) begin @(posedge clk); #1; end
                core_out_valid_i = 1'b1;
                core_out_data_i  = core_fn(blk);
                hs = 0;
                for (int t = 0; t < 200 && !hs && reset_n; t++) begin
                    @(negedge clk); hs = core_out_ready_o;
                    @(posedge clk); #1;
                end
                core_out_valid_i = 1'b0;
                core_out_data_i  = '0;
            end
        end
    end

    task automatic send_words(input int first, input int count, input int gapmax);
        bit acc;
        for (int i = first; i < first + count; i++) begin
            repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
            pt_valid_i = 1'b1;
            pt_data_i  = pt_mem[i];
            acc = 0;
            for (int t = 0; t < 500 && !acc; t++) begin
                @(negedge clk); acc = pt_ready_o;
                @(posedge clk); #1;
            end
            if (!acc) check("pt_accept_timeout", 128'(0), 128'(1));
            pt_valid_i = 1'b0;
        end
    endtask

    task automatic start_job(input logic [15:0] n);
        ctrl_engine_i.start = 1'b1;
        nblocks_i = n;
        @(posedge clk); #1;
        ctrl_engine_i.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge clk); seen = flags_engine_o.done;
        end
        if (!seen) check("done_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin : main
        bit seen;
        int hs0;
        repeat (2) @(negedge clk);
        check("rst_busy_done_cnt", 128'({flags_engine_o.busy, flags_engine_o.done, flags_engine_o.blk_cnt}), 128'(0));
        check("rst_handshake_outs", 128'({pt_ready_o, ct_valid_o, core_in_valid_o, core_out_ready_o}), 128'(0));
        check("rst_data", {core_in_data_o ^ 128'(ct_data_o)}, 128'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Known-answer single block
        pt_mem[0] = 32'h00112233; pt_mem[1] = 32'h44556677;
        pt_mem[2] = 32'h8899AABB; pt_mem[3] = 32'hCCDDEEFF;
        ct_log.delete(); done_cnt = 0;
        start_job(16'd1);
        fork send_words(0, 4, 0); wait_done(); join
        repeat (2) begin @(posedge clk); #1; end
        check("kat_core_in", last_core_in, KAT_PT);
        check("kat_ct_count", 128'(ct_log.size()), 128'(4));
        if (ct_log.size() >= 4) begin
            check("kat_ct0", 128'(ct_log[0]), 128'h69C4E0D8);
            check("kat_ct1", 128'(ct_log[1]), 128'h6A7B0430);
            check("kat_ct2", 128'(ct_log[2]), 128'hD8CDB780);
            check("kat_ct3", 128'(ct_log[3]), 128'h70B4C55A);
        end
        check("kat_done_pulses", 128'(done_cnt), 128'(1));
        check("kat_blk_cnt", 128'(flags_engine_o.blk_cnt), 128'(1));

        // Zero-block job: no handshakes, done right after start, busy one cycle
        hs0 = n_hs; done_cnt = 0; busy_cycles = 0;
        start_job(16'd0);
        repeat (5) begin @(posedge clk); #1; end
        check("zero_handshakes", 128'(n_hs - hs0), 128'(0));
        check("zero_done_pulses", 128'(done_cnt), 128'(1));
        check("zero_busy_cycles", 128'(busy_cycles), 128'(1));

        // Three blocks with random source gaps and sink back-pressure; enable toggled
        for (int i = 0; i < 12; i++) pt_mem[i] = 32'h10203040 + 32'(i) * 32'h01010101;
        ct_log.delete(); done_cnt = 0; sink_rand = 1;
        ctrl_engine_i.enable = 1'b1;
        start_job(16'd3);
        fork send_words(0, 12, 3); wait_done(); join
        sink_rand = 0; ctrl_engine_i.enable = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("multi_ct_count", 128'(ct_log.size()), 128'(12));
        check("multi_blk_cnt", 128'(flags_engine_o.blk_cnt), 128'(3));
        check("multi_done_pulses", 128'(done_cnt), 128'(1));

        // Back-pressure on the core input and the ciphertext output
        for (int i = 0; i < 4; i++) pt_mem[i] = 32'hDEAD0000 | 32'(i);
        core_stall = 3; sink_hold = 5; done_cnt = 0;
        start_job(16'd1);
        fork send_words(0, 4, 0); wait_done(); join
        core_stall = 0; sink_hold = 0;
        check("stall_done_pulses", 128'(done_cnt), 128'(1));

        // Clear after two words, with a simultaneous (ignored) start
        pt_mem[0] = 32'h11111111; pt_mem[1] = 32'h22222222;
        done_cnt = 0;
        start_job(16'd1);
        send_words(0, 2, 0);
        clear = 1'b1; ctrl_engine_i.start = 1'b1; nblocks_i = 16'd5;
        @(posedge clk); #1;
        clear = 1'b0; ctrl_engine_i.start = 1'b0;
        @(negedge clk);
        check("clear_idle", 128'(flags_engine_o.busy), 128'(0));
        check("clear_blk_cnt", 128'(flags_engine_o.blk_cnt), 128'(0));
        @(posedge clk); #1;
        pt_mem[0] = 32'hA0A1A2A3; pt_mem[1] = 32'hB0B1B2B3;
        pt_mem[2] = 32'hC0C1C2C3; pt_mem[3] = 32'hD0D1D2D3;
        start_job(16'd1);
        fork send_words(0, 4, 0); wait_done(); join
        check("clear_new_block", last_core_in, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
        check("clear_done_pulses", 128'(done_cnt), 128'(1));
        check("model_drained", 128'(exp_ct_q.size() + exp_blk_q.size() + pt_q.size()), 128'(0));

        // Asynchronous reset in the middle of DRAIN
        for (int i = 0; i < 4; i++) pt_mem[i] = 32'h5A5A0000 | 32'(i);
        sink_hold = 1000;
        start_job(16'd1);
        send_words(0, 4, 0);
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin @(negedge clk); seen = ct_valid_o; end
        check("reach_drain", 128'(seen), 128'(1));
        #2 reset_n = 1'b0;
        #1;
        check("arst_handshake_outs", 128'({pt_ready_o, ct_valid_o, core_in_valid_o, core_out_ready_o}), 128'(0));
        check("arst_flags", 128'({flags_engine_o.busy, flags_engine_o.done, flags_engine_o.blk_cnt}), 128'(0));
        check("arst_data", {core_in_data_o ^ 128'(ct_data_o)}, 128'(0));
        repeat (2) @(negedge clk);
        sink_hold = 0;
        #3 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 128'(flags_engine_o.busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
